// File: rtl/rf_wb_if.sv
// rf_wb_if: writeback requests, register-file write port and decode forwarding query
interface rf_wb_if;
  logic        alu_vld;
  logic [3:0]  alu_addr;
  logic [16:0] alu_data;
  logic        alu_rdy;
  logic        mem_vld;
  logic [3:0]  mem_addr;
  logic [16:0] mem_data;
  logic        mem_rdy;
  logic        rf_we;
  logic [3:0]  rf_w_addr;
  logic [16:0] rf_wdata;
  logic [3:0]  q_addr;
  logic        q_pend;
  logic [16:0] q_data;
  modport master (
    output alu_vld, alu_addr, alu_data, mem_vld, mem_addr, mem_data, q_addr,
    input  alu_rdy, mem_rdy, rf_we, rf_w_addr, rf_wdata, q_pend, q_data
  );
  modport slave (
    input  alu_vld, alu_addr, alu_data, mem_vld, mem_addr, mem_data, q_addr,
    output alu_rdy, mem_rdy, rf_we, rf_w_addr, rf_wdata, q_pend, q_data
  );
endinterface

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: two-requester writeback arbiter onto one register-file write port.
// Define RF_WB_ARB_FWD_EN to drive q_pend/q_data from the hold buffers.
module rf_wb_arb (
  input  logic     clk,
  input  logic     rst,
  rf_wb_if.slave   bus
);
  logic        a_full, m_full, a_age, m_age, rr;
  logic [3:0]  a_addr, m_addr;
  logic [16:0] a_data, m_data;
  logic        tie, sel_a, sel_m, a_ld, m_ld;
  // age=1 marks the entry that stayed buffered while the other was accepted
  always_comb begin
    tie   = a_full & m_full & (a_age == m_age);
    sel_a = a_full & (~m_full | (a_age & ~m_age) | (tie & ~rr));
    sel_m = m_full & ~sel_a;
    a_ld  = bus.alu_vld & bus.alu_rdy & (|bus.alu_addr);
    m_ld  = bus.mem_vld & bus.mem_rdy & (|bus.mem_addr);
  end
  assign bus.alu_rdy = rst | ~a_full | sel_a;
  assign bus.mem_rdy = rst | ~m_full | sel_m;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_full        <= 1'b0;
      m_full        <= 1'b0;
      a_age         <= 1'b0;
      m_age         <= 1'b0;
      rr            <= 1'b0;
      a_addr        <= '0;
      m_addr        <= '0;
      a_data        <= '0;
      m_data        <= '0;
      bus.rf_we     <= 1'b0;
      bus.rf_w_addr <= '0;
      bus.rf_wdata  <= '0;
    end else begin
      a_full <= a_ld | (a_full & ~sel_a);
      m_full <= m_ld | (m_full & ~sel_m);
      a_age  <= ~a_ld & a_full & ~sel_a & (m_ld | a_age);
      m_age  <= ~m_ld & m_full & ~sel_m & (a_ld | m_age);
      rr     <= rr ^ tie;
      if (a_ld) begin
        a_addr <= bus.alu_addr;
        a_data <= bus.alu_data;
      end
      if (m_ld) begin
        m_addr <= bus.mem_addr;
        m_data <= bus.mem_data;
      end
      bus.rf_we <= sel_a | sel_m;
      if (sel_a | sel_m) begin
        bus.rf_w_addr <= sel_a ? a_addr : m_addr;
        bus.rf_wdata  <= sel_a ? a_data : m_data;
      end
    end
  end
`ifdef RF_WB_ARB_FWD_EN
  logic a_hit, m_hit, use_m;
  // on a double hit the younger entry wins; same age means the one granted second
  always_comb begin
    a_hit = a_full & (a_addr == bus.q_addr);
    m_hit = m_full & (m_addr == bus.q_addr);
    use_m = m_hit & (~a_hit | a_age | (~m_age & ~rr));
  end
  assign bus.q_pend = a_hit | m_hit;
  assign bus.q_data = use_m ? m_data : a_hit ? a_data : '0;
`else
  assign bus.q_pend = 1'b0;
  assign bus.q_data = '0;
`endif
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: directed vectors for rf_wb_arb with hand-computed expectations
module tb_rf_wb_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
`ifdef RF_WB_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  rf_wb_if bus ();
  rf_wb_arb dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic v, input logic [3:0] a, input logic [16:0] d);
    bus.alu_vld = v; bus.alu_addr = a; bus.alu_data = d; #1;
  endtask
  task automatic mem(input logic v, input logic [3:0] a, input logic [16:0] d);
    bus.mem_vld = v; bus.mem_addr = a; bus.mem_data = d; #1;
  endtask
  task automatic port(input string tag, input logic we, input logic [3:0] a, input logic [16:0] d);
    chk({tag, ".we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, ".addr"}, 32'(bus.rf_w_addr), 32'(a));
    chk({tag, ".data"}, 32'(bus.rf_wdata), 32'(d));
  endtask
  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask
  initial begin
    alu(0, 0, 0); mem(0, 0, 0); bus.q_addr = 4'd0;
    do_reset();
    port("rst", 0, 0, 0);
    chk("rst.alu_rdy", 32'(bus.alu_rdy), 1);
    chk("rst.mem_rdy", 32'(bus.mem_rdy), 1);
    chk("rst.q_pend", 32'(bus.q_pend), 0);
    alu(1, 3, 17'h1ABCD);
    chk("solo.rdy", 32'(bus.alu_rdy), 1);
    tick(); alu(0, 0, 0);
    port("solo.n", 0, 0, 0);
    tick(); port("solo.n1", 1, 3, 17'h1ABCD);
    chk("solo.rdy2", 32'(bus.alu_rdy), 1);
    tick(); port("solo.idle", 0, 3, 17'h1ABCD);
    alu(1, 4, 17'h40); tick();
    alu(1, 8, 17'h80); chk("strm.rdy", 32'(bus.alu_rdy), 1); tick();
    port("strm.0", 1, 4, 17'h40);
    alu(1, 9, 17'h90); tick();
    port("strm.1", 1, 8, 17'h80);
    alu(0, 0, 0); tick();
    port("strm.2", 1, 9, 17'h90);
    tick(); port("strm.idle", 0, 9, 17'h90);
    do_reset();
    alu(1, 5, 17'h11); mem(1, 6, 17'h22); tick(); alu(0, 0, 0); mem(0, 0, 0);
    chk("c1.alu_rdy", 32'(bus.alu_rdy), 1);
    chk("c1.mem_rdy", 32'(bus.mem_rdy), 0);
    tick(); port("c1.first", 1, 5, 17'h11);
    tick(); port("c1.second", 1, 6, 17'h22);
    tick(); port("c1.idle", 0, 6, 17'h22);
    alu(1, 5, 17'h33); mem(1, 6, 17'h44); tick(); alu(0, 0, 0); mem(0, 0, 0);
    chk("c2.alu_rdy", 32'(bus.alu_rdy), 0);
    tick(); port("c2.first", 1, 6, 17'h44);
    tick(); port("c2.second", 1, 5, 17'h33);
    tick();
    alu(1, 1, 17'h101); mem(1, 2, 17'h202); tick(); mem(0, 0, 0);
    alu(1, 7, 17'h707);
    chk("age.alu_rdy", 32'(bus.alu_rdy), 1);
    chk("age.mem_rdy", 32'(bus.mem_rdy), 0);
    tick(); alu(0, 0, 0);
    port("age.0", 1, 1, 17'h101);
    tick(); port("age.1", 1, 2, 17'h202);
    tick(); port("age.2", 1, 7, 17'h707);
    tick(); port("age.idle", 0, 7, 17'h707);
    alu(1, 0, 17'h1FFFF);
    chk("z.rdy", 32'(bus.alu_rdy), 1);
    tick(); alu(0, 0, 0);
    chk("z.rdy2", 32'(bus.alu_rdy), 1);
    tick(); port("z.0", 0, 7, 17'h707);
    tick(); port("z.1", 0, 7, 17'h707);
    mem(1, 9, 17'h00042); bus.q_addr = 4'd9; tick(); mem(0, 0, 0);
    chk("fwd.pend", 32'(bus.q_pend), 32'(FWD));
    chk("fwd.data", 32'(bus.q_data), FWD ? 32'h42 : 32'h0);
    bus.q_addr = 4'd4; #1;
    chk("fwd.miss", 32'(bus.q_pend), 0);
    bus.q_addr = 4'd9;
    tick(); port("fwd.issue", 1, 9, 17'h42);
    chk("fwd.gone", 32'(bus.q_pend), 0);
    tick();
    alu(1, 4'hA, 17'h0AA); mem(1, 4'hB, 17'h0BB); tick();
    rst = 1'b1; #1;
    chk("rr.alu_rdy", 32'(bus.alu_rdy), 1);
    chk("rr.mem_rdy", 32'(bus.mem_rdy), 1);
    tick(); alu(0, 0, 0); mem(0, 0, 0);
    port("rr.0", 0, 0, 0);
    rst = 1'b0; #1;
    chk("rr.alu_rdy2", 32'(bus.alu_rdy), 1);
    chk("rr.mem_rdy2", 32'(bus.mem_rdy), 1);
    for (int i = 0; i < 4; i++) begin
      tick(); port($sformatf("rr.drop%0d", i), 0, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
